// File: rtl/alu_pipe.sv
// Registered ALU with a valid/ready handshake on both sides. Single-cycle ops
// produce a result one cycle after acceptance; MUL uses an iterative shift-add.
module alu_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic               w_wr;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [WIDTH-1:0]   w_wr_res;
  logic               w_wr_c;
  logic               w_wr_v;

  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (op == 3'b110) && MUL_EN;
  assign w_mul_done  = (r_state == S_MUL) && (r_cnt == '0);
  assign w_wr        = (w_accept && !w_mul_start) || w_mul_done;
  assign out_valid   = r_out_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_mul_start) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    busy     = (r_state == S_MUL);
  end

  // Single-cycle datapath; op 110 lands in default (reserved) when MUL_EN=0.
  always_comb begin
    w_sum  = {1'b0, a} + {1'b0, b};
    w_diff = {1'b0, a} - {1'b0, b};
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    unique case (op)
      3'b000: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  w_res = a & b;
      3'b011:  w_res = a | b;
      3'b100:  w_res = ~a;
      3'b101:  w_res = a ^ b;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_wr_res = w_mul_done ? r_acc[WIDTH-1:0]       : w_res;
    w_wr_c   = w_mul_done ? |r_acc[2*WIDTH-1:WIDTH] : w_c;
    w_wr_v   = w_mul_done ? 1'b0                    : w_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      result      <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      flag_v      <= 1'b0;
      flag_n      <= 1'b0;
    end else if (w_wr) begin
      r_out_valid <= 1'b1;
      result      <= w_wr_res;
      flag_z      <= (w_wr_res == '0);
      flag_c      <= w_wr_c;
      flag_v      <= w_wr_v;
      flag_n      <= w_wr_res[WIDTH-1];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Counter reaching zero marks the write cycle, giving WIDTH+1 cycles latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_mul_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH);
    end else if ((r_state == S_MUL) && (r_cnt != '0)) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. It accepts one operation per valid/ready handshake and returns a registered result with status flags. It adds XOR and a multi-cycle shift-add multiply. It sits between an operand-issue stage and a result consumer, and both sides may stall.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
MUL_EN, 1, 1 = op 110 performs multiply; 0 = op 110 behaves as reserved (result 0)

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A, 101 XOR, 110 MUL, 111 reserved
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result
result  output  WIDTH  registered result
flag_z  output  1  result == 0
flag_c  output  1  carry / borrow / multiply overflow
flag_v  output  1  signed overflow
flag_n  output  1  result[WIDTH-1]
busy  output  1  multiply in progress

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE; out_valid, busy, result and all flags = 0. in_ready = 1 in the first cycle after rst deasserts.
- Accept: a transfer occurs on a rising edge where in_valid && in_ready. a, b and op are sampled on that edge only.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational from out_ready; there is no path from in_valid.
- Output hold: while out_valid && !out_ready, result and the flags are frozen.
- out_valid clears on out_ready unless a new result is written on the same edge.
- FSM states: IDLE and MUL.
- IDLE: single-cycle ops write the output register on the accepting edge. out_valid is high the next cycle (latency 1). Back-to-back throughput is 1 op/cycle while out_ready = 1.
- IDLE -> MUL: on accepting op 110 with MUL_EN=1. Load multiplicand, multiplier and a 2*WIDTH accumulator; counter = WIDTH; busy = 1.
- MUL state: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and decrement the counter.
- MUL -> IDLE: when the counter reaches 0, write the low WIDTH bits to result. out_valid rises exactly WIDTH+1 cycles after the accepting edge; busy drops in the same cycle. in_ready is 0 throughout MUL.
- The MUL result write cannot collide with a held output, because MUL is only entered when the output slot will be free.
- Flags by op:
  - ADD: C = carry out of bit WIDTH-1; V = (a[msb]==b[msb]) && (res[msb]!=a[msb]).
  - SUB: res = a - b mod 2^WIDTH; C = 1 iff a < b unsigned (borrow); V = (a[msb]!=b[msb]) && (res[msb]!=a[msb]).
  - MUL: C = 1 iff the high WIDTH bits of the product are nonzero; V = 0.
  - AND/OR/NOT/XOR/reserved: C = V = 0.
  - All ops: Z and N are computed from the written result.
- Reserved op (111, or 110 with MUL_EN=0): result 0, Z=1, latency 1, accepted normally.
- rst during MUL: abort. On the same edge return to IDLE; out_valid=0, busy=0, accumulator discarded. No stale result ever appears.
- rst overrides any simultaneous accept or out_ready.

Test Plan:
- WIDTH=8. ADD a=0xFF, b=0x01 -> one cycle later out_valid=1, result=0x00, Z=1, C=1, V=0, N=0. ADD 0x7F+0x01 -> 0x80, V=1, N=1, C=0.
- SUB 0x80-0x01 -> 0x7F, V=1, C=0. SUB 0x02-0x08 -> 0xFA, C=1, N=1, V=0.
- MUL 0x0F*0x11 -> result 0xFF, C=0. out_valid exactly 9 cycles after accept; in_ready=0 and busy=1 for the intervening cycles. MUL 0x10*0x10 -> 0x00, C=1, Z=1.
- Backpressure: hold out_ready=0 and issue AND 0xCC&0xAA. Result 0x88 stays frozen and in_ready=0 while the second op is held. Raise out_ready: 0x88 is consumed and the second op is accepted on the same edge. Then stream 4 ADDs with out_ready=1 -> 4 results on 4 consecutive cycles.
- Reset mid-operation: start MUL 0x03*0x05 and assert rst on the 4th MUL cycle. Next cycle out_valid=0, busy=0, result=0. After release, in_ready=1, and a following ADD 1+1 -> 0x02 with no 0x0F ever output.
- WIDTH=4 instance: NOT 0xA -> 0x5; XOR 0xC^0xA -> 0x6; op 111 -> 0x0, Z=1. With a MUL_EN=0 instance, op 110 with 3*5 -> 0x0, latency 1.
